// File: rtl/mipi_tx_lane_ctrl.sv
// D-PHY data-lane burst sequencer feeding the MIPI_TX serializer.
// Walks LP-11 -> LP-01 -> LP-00 -> HS-zero -> sync -> payload -> HS-trail -> LP-11 exit.
// Every output is registered and is decoded from the next state, so state and
// outputs change on the same edge.
module mipi_tx_lane_ctrl #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned T_LPX   = 4,
  parameter int unsigned T_PREP  = 3,
  parameter int unsigned T_ZERO  = 8,
  parameter int unsigned T_TRAIL = 6,
  parameter int unsigned T_EXIT  = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TX_REQ,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             DATA_VALID,
  input  logic             DATA_LAST,
  output logic             DATA_READY,
  output logic [WIDTH-1:0] HS_TX_DATA,
  output logic             HS_TXD_VALID,
  output logic             HS_EN,
  output logic             LP_EN,
  output logic             TX_LP_DP,
  output logic             TX_LP_DN,
  output logic             TX_ODT_EN,
  output logic             BUSY,
  output logic             STOP_STATE,
  output logic             ERR_UNDERFLOW
);

  // Durations of 0 are promoted to 1 so every state lasts at least one cycle.
  localparam logic [7:0] LpxCnt   = (T_LPX   == 0) ? 8'd1 : 8'(T_LPX);
  localparam logic [7:0] PrepCnt  = (T_PREP  == 0) ? 8'd1 : 8'(T_PREP);
  localparam logic [7:0] ZeroCnt  = (T_ZERO  == 0) ? 8'd1 : 8'(T_ZERO);
  localparam logic [7:0] TrailCnt = (T_TRAIL == 0) ? 8'd1 : 8'(T_TRAIL);
  localparam logic [7:0] ExitCnt  = (T_EXIT  == 0) ? 8'd1 : 8'(T_EXIT);
  // A 4-bit lane sends the sync byte as two nibbles, low nibble first.
  localparam logic [7:0] SyncCnt  = (WIDTH == 8) ? 8'd1 : 8'd2;

  localparam logic [15:0]      SyncExt = 16'h00B8;
  localparam logic [WIDTH-1:0] SyncLo  = SyncExt[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SyncHi  = SyncExt[2*WIDTH-1:WIDTH];

  // StLast is the DATA cycle that holds the final word with DATA_READY low.
  typedef enum logic [3:0] {
    StStop, StLpx, StPrep, StZero, StSync, StData, StLast, StTrail, StExit
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] hs_data_q, hs_data_d;
  logic             hs_en_q, hs_en_d;
  logic             hs_vld_q, hs_vld_d;
  logic             lp_en_q, lp_en_d;
  logic             lp_dp_q, lp_dp_d;
  logic             lp_dn_q, lp_dn_d;
  logic             odt_q, odt_d;
  logic             busy_q, busy_d;
  logic             stop_q, stop_d;
  logic             take;

  // Next state, duration counter and sticky underflow flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    take    = ready_q & DATA_VALID;
    unique case (state_q)
      StStop: begin
        if (TX_REQ) begin
          state_d = StLpx;
          cnt_d   = LpxCnt;
          err_d   = 1'b0;
        end
      end
      StLpx: begin
        if (cnt_q == 8'd1) begin
          state_d = StPrep;
          cnt_d   = PrepCnt;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StPrep: begin
        if (cnt_q == 8'd1) begin
          state_d = StZero;
          cnt_d   = ZeroCnt;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StZero: begin
        if (cnt_q == 8'd1) begin
          state_d = StSync;
          cnt_d   = SyncCnt;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StSync: begin
        if (cnt_q == 8'd1) begin
          state_d = StData;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StData: begin
        state_d = StData;
      end
      StLast: begin
        state_d = StTrail;
        cnt_d   = TrailCnt;
      end
      StTrail: begin
        if (cnt_q == 8'd1) begin
          state_d = StExit;
          cnt_d   = ExitCnt;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StExit: begin
        if (cnt_q == 8'd1) begin
          state_d = StStop;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = StStop;
    endcase
    // A payload slot is any cycle with DATA_READY high, including the last sync cycle.
    if (ready_q) begin
      if (DATA_VALID) begin
        if (DATA_LAST) begin
          state_d = StLast;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Output decode from the next state so outputs land on the same edge as the state.
  always_comb begin
    hs_data_d = '0;
    hs_en_d   = 1'b0;
    hs_vld_d  = 1'b0;
    lp_en_d   = 1'b0;
    lp_dp_d   = 1'b0;
    lp_dn_d   = 1'b0;
    odt_d     = 1'b0;
    stop_d    = 1'b0;
    busy_d    = (state_d != StStop);
    ready_d   = (state_d == StData) || ((state_d == StSync) && (cnt_d == 8'd1));
    unique case (state_d)
      StStop: begin
        lp_en_d = 1'b1;
        lp_dp_d = 1'b1;
        lp_dn_d = 1'b1;
        stop_d  = 1'b1;
      end
      StLpx: begin
        lp_en_d = 1'b1;
        lp_dn_d = 1'b1;
      end
      StPrep: begin
        lp_en_d = 1'b1;
        odt_d   = 1'b1;
      end
      StZero: begin
        hs_en_d  = 1'b1;
        hs_vld_d = 1'b1;
        odt_d    = 1'b1;
      end
      StSync: begin
        hs_en_d   = 1'b1;
        hs_vld_d  = 1'b1;
        odt_d     = 1'b1;
        hs_data_d = ((WIDTH == 4) && (cnt_d == 8'd1)) ? SyncHi : SyncLo;
      end
      StData, StLast: begin
        hs_en_d   = 1'b1;
        hs_vld_d  = 1'b1;
        odt_d     = 1'b1;
        // Underflow slots send an all-zero word and the burst carries on.
        hs_data_d = take ? DATA_IN : '0;
      end
      StTrail: begin
        hs_en_d   = 1'b1;
        hs_vld_d  = 1'b1;
        odt_d     = 1'b1;
        // On entry hs_data_q still holds the final payload word.
        hs_data_d = (state_q == StTrail) ? hs_data_q : {WIDTH{~hs_data_q[WIDTH-1]}};
      end
      StExit: begin
        lp_en_d = 1'b1;
        lp_dp_d = 1'b1;
        lp_dn_d = 1'b1;
      end
      default: begin
        lp_en_d = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset forces LP-11 STOP values immediately.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StStop;
      cnt_q     <= 8'd0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      hs_data_q <= '0;
      hs_en_q   <= 1'b0;
      hs_vld_q  <= 1'b0;
      lp_en_q   <= 1'b1;
      lp_dp_q   <= 1'b1;
      lp_dn_q   <= 1'b1;
      odt_q     <= 1'b0;
      busy_q    <= 1'b0;
      stop_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      hs_data_q <= hs_data_d;
      hs_en_q   <= hs_en_d;
      hs_vld_q  <= hs_vld_d;
      lp_en_q   <= lp_en_d;
      lp_dp_q   <= lp_dp_d;
      lp_dn_q   <= lp_dn_d;
      odt_q     <= odt_d;
      busy_q    <= busy_d;
      stop_q    <= stop_d;
    end
  end

  assign DATA_READY    = ready_q;
  assign HS_TX_DATA    = hs_data_q;
  assign HS_TXD_VALID  = hs_vld_q;
  assign HS_EN         = hs_en_q;
  assign LP_EN         = lp_en_q;
  assign TX_LP_DP      = lp_dp_q;
  assign TX_LP_DN      = lp_dn_q;
  assign TX_ODT_EN     = odt_q;
  assign BUSY          = busy_q;
  assign STOP_STATE    = stop_q;
  assign ERR_UNDERFLOW = err_q;

endmodule

// File: tb/tb_mipi_tx_lane_ctrl.sv
// Directed bench for mipi_tx_lane_ctrl: a 4-bit lane and an 8-bit lane, default timings.
module tb_mipi_tx_lane_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-bit lane
  logic       rst4, req4, valid4, last4;
  logic [3:0] din4, hs4;
  logic       ready4, hsv4, hsen4, lpen4, dp4, dn4, odt4, busy4, stop4, err4;
  // 8-bit lane
  logic       rst8, req8, valid8, last8;
  logic [7:0] din8, hs8;
  logic       ready8, hsv8, hsen8, lpen8, dp8, dn8, odt8, busy8, stop8, err8;

  int n_cmp = 0;
  int n_bad = 0;

  mipi_tx_lane_ctrl #(.WIDTH(4)) u_dut4 (
    .CLK(clk), .RST(rst4), .TX_REQ(req4), .DATA_IN(din4), .DATA_VALID(valid4),
    .DATA_LAST(last4), .DATA_READY(ready4), .HS_TX_DATA(hs4), .HS_TXD_VALID(hsv4),
    .HS_EN(hsen4), .LP_EN(lpen4), .TX_LP_DP(dp4), .TX_LP_DN(dn4), .TX_ODT_EN(odt4),
    .BUSY(busy4), .STOP_STATE(stop4), .ERR_UNDERFLOW(err4)
  );

  mipi_tx_lane_ctrl #(.WIDTH(8)) u_dut8 (
    .CLK(clk), .RST(rst8), .TX_REQ(req8), .DATA_IN(din8), .DATA_VALID(valid8),
    .DATA_LAST(last8), .DATA_READY(ready8), .HS_TX_DATA(hs8), .HS_TXD_VALID(hsv8),
    .HS_EN(hsen8), .LP_EN(lpen8), .TX_LP_DP(dp8), .TX_LP_DN(dn8), .TX_ODT_EN(odt8),
    .BUSY(busy8), .STOP_STATE(stop8), .ERR_UNDERFLOW(err8)
  );

  // Control vector order: lp_en dp dn hs_en hs_valid odt ready stop busy
  function automatic logic [8:0] ctl4();
    return {lpen4, dp4, dn4, hsen4, hsv4, odt4, ready4, stop4, busy4};
  endfunction

  function automatic logic [8:0] ctl8();
    return {lpen8, dp8, dn8, hsen8, hsv8, odt8, ready8, stop8, busy8};
  endfunction

  // Expected control vector at edge e of a burst launched at edge 0.
  // se = last sync edge, l = DATA_LAST handshake edge.
  function automatic logic [8:0] exp_ctl(input int e, input int se, input int l);
    logic rdy;
    rdy = (e >= se) && (e < l);
    if (e <= 3)      return 9'b101000001;
    if (e <= 6)      return 9'b100001001;
    if (e <= l + 6)  return {6'b000111, rdy, 2'b01};
    if (e <= l + 12) return 9'b111000001;
    return 9'b111000010;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One 4-bit burst of three words, optionally with an empty slot after the first.
  task automatic burst4(input logic [3:0] w0, input logic [3:0] w1, input logic [3:0] w2,
                        input bit gap, input string name);
    logic [3:0] sd [4];
    logic       sv [4];
    int         ns, l;
    logic [3:0] trail, ed;
    if (gap) begin
      sd[0] = w0; sd[1] = 4'hF; sd[2] = w1; sd[3] = w2;
      sv[0] = 1'b1; sv[1] = 1'b0; sv[2] = 1'b1; sv[3] = 1'b1;
      ns = 4;
    end else begin
      sd[0] = w0; sd[1] = w1; sd[2] = w2; sd[3] = 4'h0;
      sv[0] = 1'b1; sv[1] = 1'b1; sv[2] = 1'b1; sv[3] = 1'b0;
      ns = 3;
    end
    l = 16 + ns;
    trail = {4{~w2[3]}};
    req4 = 1'b1;
    tick();
    req4 = 1'b0;
    chk($sformatf("%s e0 ctl", name), 32'(ctl4()), 32'(exp_ctl(0, 16, l)));
    chk($sformatf("%s e0 err", name), 32'(err4), 32'd0);
    for (int e = 1; e <= l + 13; e++) begin
      if (e >= 17 && e <= l) begin
        valid4 = sv[e-17];
        din4   = sd[e-17];
        last4  = (e == l);
      end else begin
        valid4 = 1'b0;
        din4   = 4'h0;
        last4  = 1'b0;
      end
      tick();
      if (e >= 15 && e <= 16)          ed = (e == 15) ? 4'h8 : 4'hB;
      else if (e >= 17 && e <= l)      ed = sv[e-17] ? sd[e-17] : 4'h0;
      else if (e > l && e <= l + 6)    ed = trail;
      else                             ed = 4'h0;
      chk($sformatf("%s e%0d ctl", name, e), 32'(ctl4()), 32'(exp_ctl(e, 16, l)));
      chk($sformatf("%s e%0d data", name, e), 32'(hs4), 32'(ed));
      chk($sformatf("%s e%0d err", name, e), 32'(err4), 32'(gap && e >= 18));
    end
    valid4 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst4 = 1'b1; req4 = 1'b0; valid4 = 1'b0; last4 = 1'b0; din4 = 4'h0;
    rst8 = 1'b1; req8 = 1'b0; valid8 = 1'b0; last8 = 1'b0; din8 = 8'h00;
    tick();
    tick();
    chk("reset4 ctl", 32'(ctl4()), 32'(9'b111000010));
    chk("reset4 data", 32'(hs4), 32'd0);
    chk("reset4 err", 32'(err4), 32'd0);
    chk("reset8 ctl", 32'(ctl8()), 32'(9'b111000010));
    chk("reset8 data", 32'(hs8), 32'd0);
    rst4 = 1'b0;
    rst8 = 1'b0;
    tick();
    chk("idle4 ctl", 32'(ctl4()), 32'(9'b111000010));

    // Back-to-back payload, last word MSB set -> trail of zeros.
    burst4(4'h5, 4'h3, 4'hA, 1'b0, "b1");
    // Underflow slot after the first word, last word MSB clear -> trail of ones.
    burst4(4'h6, 4'h9, 4'h2, 1'b1, "b2");
    tick();
    chk("b2 sticky err", 32'(err4), 32'd1);
    chk("b2 stop ctl", 32'(ctl4()), 32'(9'b111000010));

    // Launch clears the flag; reset during DATA drops straight to STOP.
    req4 = 1'b1;
    tick();
    req4 = 1'b0;
    chk("b3 err cleared", 32'(err4), 32'd0);
    for (int e = 1; e <= 16; e++) tick();
    chk("b3 ready", 32'(ready4), 32'd1);
    valid4 = 1'b1;
    din4   = 4'hC;
    tick();
    chk("b3 word", 32'(hs4), 32'hC);
    chk("b3 hs_en", 32'(hsen4), 32'd1);
    rst4   = 1'b1;
    valid4 = 1'b0;
    tick();
    chk("abort ctl", 32'(ctl4()), 32'(9'b111000010));
    chk("abort data", 32'(hs4), 32'd0);
    rst4 = 1'b0;
    tick();
    chk("abort idle", 32'(ctl4()), 32'(9'b111000010));

    // 8-bit lane with TX_REQ held high for the whole burst and beyond.
    req8 = 1'b1;
    tick();
    chk("w8 e0 ctl", 32'(ctl8()), 32'(exp_ctl(0, 15, 17)));
    for (int e = 1; e <= 31; e++) begin
      logic [7:0] ed;
      valid8 = (e == 16) || (e == 17);
      din8   = (e == 16) ? 8'h11 : ((e == 17) ? 8'h80 : 8'h00);
      last8  = (e == 17);
      tick();
      if (e == 15)      ed = 8'hB8;
      else if (e == 16) ed = 8'h11;
      else if (e == 17) ed = 8'h80;
      else              ed = 8'h00;
      chk($sformatf("w8 e%0d ctl", e), 32'(ctl8()),
          (e == 31) ? 32'(exp_ctl(0, 15, 17)) : 32'(exp_ctl(e, 15, 17)));
      chk($sformatf("w8 e%0d data", e), 32'(hs8), 32'(ed));
    end
    chk("w8 err", 32'(err8), 32'd0);
    req8 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
